player_input_scheduler: RTL

Sequences decoded keyboard key levels into game-rate commands. Runs the top-level game-state FSM (idle/play/pause) from the Enter and Esc keys, and generates a periodic movement tick that samples both players' direction keys. Arbitrates a single shared bullet-spawn port between the two players' fire requests, using round-robin grant and a per-player cooldown. Sits between the keyboard decoder and the game-logic/sprite datapath; all inputs and outputs are in the `clk` domain.

---
 rtl/player_input_scheduler.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/player_input_scheduler.sv
// player_input_scheduler
//   Turns decoded keyboard levels into game-rate commands.
//   - Runs the IDLE/PLAY/PAUSE game-state FSM from Enter (start) and Esc (ResetGame).
//   - Produces a periodic movement tick in PLAY and samples both players' direction keys.
//   - Arbitrates one bullet-spawn port between two fire requests. Ties are broken
//     round-robin, and each player has a cooldown counted in ticks.
// Ports
//   clk, reset          : system clock, asynchronous active-high reset
//   W,A,S,D / I,J,K,L   : player 1 / player 2 direction key levels (up,left,down,right)
//   fire1, fire2        : fire key levels
//   start, ResetGame    : Enter / Esc key levels
//   game_state          : 0=IDLE 1=PLAY 2=PAUSE
//   game_reset          : one-cycle pulse when Esc is pressed
//   tick                : one-cycle movement strobe
//   move_valid          : one-cycle pulse; p1_move/p2_move are {up,left,down,right}
//   spawn_valid/_player : spawn request and the granted player, held until spawn_ready
module player_input_scheduler #(
    parameter int unsigned MOVE_DIV      = 833333,
    parameter int unsigned FIRE_COOLDOWN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       W,
    input  logic       A,
    input  logic       S,
    input  logic       D,
    input  logic       I,
    input  logic       J,
    input  logic       K,
    input  logic       L,
    input  logic       fire1,
    input  logic       fire2,
    input  logic       start,
    input  logic       ResetGame,
    output logic [1:0] game_state,
    output logic       game_reset,
    output logic       tick,
    output logic       move_valid,
    output logic [3:0] p1_move,
    output logic [3:0] p2_move,
    output logic       spawn_valid,
    output logic       spawn_player,
    input  logic       spawn_ready
);

    localparam int unsigned      CNT_W    = $clog2(MOVE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_DIV - 1);
    localparam logic [7:0]       CD_LOAD  = 8'(FIRE_COOLDOWN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             start_q, start_d;
    logic             esc_q, esc_d;
    logic             game_reset_q, game_reset_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cd1_q, cd1_d;
    logic [7:0]       cd2_q, cd2_d;
    logic             last_grant_q, last_grant_d;
    logic             move_valid_q, move_valid_d;
    logic [3:0]       p1_move_q, p1_move_d;
    logic [3:0]       p2_move_q, p2_move_d;
    logic             spawn_valid_q, spawn_valid_d;
    logic             spawn_player_q, spawn_player_d;

    logic start_rise, esc_rise, tick_w, pend1, pend2, xfer;

    // Opposing keys cancel each other out.
    function automatic logic [3:0] dir4(input logic up, input logic left,
                                        input logic down, input logic right);
        return {up & ~down, left & ~right, down & ~up, right & ~left};
    endfunction

    assign start_rise = start & ~start_q;
    assign esc_rise   = ResetGame & ~esc_q;
    // Gating with PLAY stops a counter frozen at its last value from ticking in PAUSE.
    assign tick_w     = (state_q == ST_PLAY) && (cnt_q == CNT_LAST);
    assign pend1      = fire1 & (cd1_q == '0) & (state_q == ST_PLAY);
    assign pend2      = fire2 & (cd2_q == '0) & (state_q == ST_PLAY);
    assign xfer       = spawn_valid_q & spawn_ready;

    always_comb begin
        state_d        = state_q;
        start_d        = start;
        esc_d          = ResetGame;
        game_reset_d   = 1'b0;
        cnt_d          = cnt_q;
        cd1_d          = cd1_q;
        cd2_d          = cd2_q;
        last_grant_d   = last_grant_q;
        move_valid_d   = 1'b0;
        p1_move_d      = p1_move_q;
        p2_move_d      = p2_move_q;
        spawn_valid_d  = spawn_valid_q;
        spawn_player_d = spawn_player_q;

        if (esc_rise) begin
            // The flush lands on the same edge that raises game_reset. This drops a
            // pending spawn without a handshake.
            state_d        = ST_IDLE;
            game_reset_d   = 1'b1;
            cnt_d          = '0;
            cd1_d          = '0;
            cd2_d          = '0;
            last_grant_d   = 1'b1;
            p1_move_d      = '0;
            p2_move_d      = '0;
            spawn_valid_d  = 1'b0;
            spawn_player_d = 1'b0;
        end else begin
            if (start_rise) begin
                case (state_q)
                    ST_IDLE:  state_d = ST_PLAY;
                    ST_PLAY:  state_d = ST_PAUSE;
                    ST_PAUSE: state_d = ST_PLAY;
                    default:  state_d = ST_IDLE;
                endcase
            end

            case (state_q)
                ST_PLAY:  cnt_d = tick_w ? '0 : cnt_q + CNT_W'(1);
                ST_PAUSE: cnt_d = cnt_q;
                default:  cnt_d = '0;
            endcase

            if (tick_w) begin
                move_valid_d = 1'b1;
                p1_move_d    = dir4(W, A, S, D);
                p2_move_d    = dir4(I, J, K, L);
            end

            // A load after an accepted spawn takes priority over a tick decrement.
            if (xfer && !spawn_player_q)
                cd1_d = CD_LOAD;
            else if (tick_w && cd1_q != '0)
                cd1_d = cd1_q - 8'd1;

            if (xfer && spawn_player_q)
                cd2_d = CD_LOAD;
            else if (tick_w && cd2_q != '0)
                cd2_d = cd2_q - 8'd1;

            if (xfer) begin
                spawn_valid_d = 1'b0;
                last_grant_d  = spawn_player_q;
            end else if (!spawn_valid_q && (pend1 || pend2)) begin
                spawn_valid_d  = 1'b1;
                spawn_player_d = (pend1 && pend2) ? ~last_grant_q : pend2;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            start_q        <= 1'b0;
            esc_q          <= 1'b0;
            game_reset_q   <= 1'b0;
            cnt_q          <= '0;
            cd1_q          <= '0;
            cd2_q          <= '0;
            last_grant_q   <= 1'b1;
            move_valid_q   <= 1'b0;
            p1_move_q      <= '0;
            p2_move_q      <= '0;
            spawn_valid_q  <= 1'b0;
            spawn_player_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            esc_q          <= esc_d;
            game_reset_q   <= game_reset_d;
            cnt_q          <= cnt_d;
            cd1_q          <= cd1_d;
            cd2_q          <= cd2_d;
            last_grant_q   <= last_grant_d;
            move_valid_q   <= move_valid_d;
            p1_move_q      <= p1_move_d;
            p2_move_q      <= p2_move_d;
            spawn_valid_q  <= spawn_valid_d;
            spawn_player_q <= spawn_player_d;
        end
    end

    assign game_state   = state_q;
    assign game_reset   = game_reset_q;
    assign tick         = tick_w;
    assign move_valid   = move_valid_q;
    assign p1_move      = p1_move_q;
    assign p2_move      = p2_move_q;
    assign spawn_valid  = spawn_valid_q;
    assign spawn_player = spawn_player_q;

endmodule
